state_unpack_cit__poly_decompress: RTL and testbench
====================================================

# state_unpack_cit__poly_decompress

Streaming decompressor for one packed ciphertext polynomial. It is the receive-side counterpart of the pack/compress stage. It accepts packed D-bit compressed coefficients as a byte stream, regroups every D bytes into 8 coefficients t0..t7, and emits decompressed values (t·KYBER_Q + 2^(D−1)) >> D as eight 12-bit lanes per handshake. It sits between the ciphertext byte buffer and the decryption datapath, and processes exactly KYBER_N coefficients per start.

## Interface
- KYBER_N, 256, coefficients per polynomial; must be a multiple of 8
- KYBER_Q, 3329, modulus
- D, 3, compressed bit width per coefficient (1..11)
- o_Width, 12, decompressed coefficient width
- clk  input  1  rising-edge clock; the block's only clock
- rst  input  1  synchronous, active-high reset
- iStart  input  1  begin one polynomial; sampled only in IDLE
- iByte  input  8  packed ciphertext byte
- iByteValid  input  1  iByte is valid
- oByteReady  output  1  block accepts iByte this cycle
- oPolyCoeffs0..oPolyCoeffs7  output  o_Width each  decompressed coefficients of the current group
- oCoeffValid  output  1  the oPolyCoeffs lanes are valid
- iCoeffReady  input  1  downstream accepts the group
- oBusy  output  1  high whenever state ≠ IDLE
- oDone  output  1  one-cycle pulse after the last group handshake

## Operation
- States: IDLE, LOAD, EMIT. A MUL state exists only when the configuration macro is defined.
- IDLE: oByteReady=0. iStart=1 moves to LOAD and clears byteCnt and groupCnt.
- LOAD: oByteReady=1. Each byte handshake (iByteValid & oByteReady) stores the byte at bits [8·byteCnt +: 8] of a D·8-bit word, with byte 0 in the LSBs. After the D-th byte, go to EMIT, or to MUL when the macro is defined.
- Unpacking: t_j = word[D·j +: D], for j = 0..7.
- Arithmetic: product = t_j·KYBER_Q + 2^(D−1), computed at D+12 bits with no truncation. Result = product >> D, which is always < KYBER_Q and fits o_Width.
- EMIT: oCoeffValid=1 and the lanes stay stable until iCoeffReady=1. On that handshake, groupCnt increments. If groupCnt was KYBER_N/8−1, pulse oDone and go to IDLE. Otherwise go to LOAD.
- iStart is ignored outside IDLE.
- No new byte is accepted while in EMIT, so one group buffer is sufficient.
- rst, including mid-polynomial, forces IDLE and discards any partial word and counters.

## Timing
- Reset values: oByteReady=0, oCoeffValid=0, oBusy=0, oDone=0, oPolyCoeffs*=0.
- oByteReady is high starting the cycle after iStart is accepted.
- Without the macro, oCoeffValid rises the cycle after the D-th byte handshake (latency 1).
- Peak rate is one group per D+1 cycles. With D=3 and KYBER_N=256, a polynomial is 96 bytes and 32 groups, taking at least 128 cycles plus 1.
- oDone is high in the cycle after the final group handshake, with oBusy=0 in that same cycle.
- Back-to-back polynomials: iStart may be asserted in the same cycle oDone is high.

## Configuration
- STATE_UNPACK_MUL_PIPE_EN
  - Defined: the multiply is registered in an extra MUL state. oCoeffValid rises 2 cycles after the D-th byte, and the rate is one group per D+2 cycles.
  - Undefined: the multiply is combinational into the output register, giving latency 1.
- Functional results are identical in both builds.

## Structure
- The shared package holds:
  - the state enum
  - the KYBER_Q and KYBER_N constants
  - a decompress function computing (t·KYBER_Q + 2^(D−1)) >> D
- One sub-module, poly_decompress_lane: a single D→12-bit decompressor, instantiated 8 times.

## Test plan
- D=3, bytes 0x88, 0xC6, 0xFA, ready held high → t=0..7, lanes = 0, 416, 832, 1248, 1665, 2081, 2497, 2913, one cycle after the third byte.
- Full polynomial of 96 bytes of 0xFF → 32 groups of all lanes = 2913, then oDone pulses exactly once and oBusy drops.
- iCoeffReady held low 5 cycles during EMIT → lanes stable, oByteReady=0, no byte consumed. When ready rises, the next group proceeds normally.
- iByteValid toggled randomly → byte order is preserved and results match the reference model. iStart pulsed mid-polynomial → ignored.
- rst asserted after 40 bytes → next cycle all outputs are 0 and state is IDLE. A new iStart with 96 bytes decodes correctly, with no residue from the earlier partial word.
- Build with STATE_UNPACK_MUL_PIPE_EN → first scenario values appear 2 cycles after the third byte. Output streams are bit-identical to the default build.

Source files
------------

// File: rtl/state_unpack_cit__poly_decompress_pkg.sv
// Shared definitions for the ciphertext polynomial decompressor:
// Kyber constants, FSM state encoding and the scalar decompress function.
package state_unpack_cit__poly_decompress_pkg;

  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;

  // State encoding. ST_MUL is only reachable when STATE_UNPACK_MUL_PIPE_EN is defined.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;
  localparam logic [1:0] ST_MUL  = 2'd3;

  // Rounds a d-bit compressed value back into [0, KYBER_Q):
  // (t * KYBER_Q + 2^(d-1)) >> d. 24 bits holds the product for any d up to 11.
  function automatic logic [11:0] decompress(input logic [10:0] t, input int d);
    logic [23:0] product;
    product = 24'(t) * 24'(KYBER_Q) + (24'(1) << (d - 1));
    return 12'(product >> d);
  endfunction

endpackage

// File: rtl/state_unpack_cit__poly_decompress_lane.sv
// One decompression lane: maps a D-bit compressed coefficient to its 12-bit value.
module poly_decompress_lane
  import state_unpack_cit__poly_decompress_pkg::*;
#(
  parameter int D = 3
) (
  input  logic [D-1:0] t,
  output logic [11:0]  coeff
);

  // Purely combinational; the parent decides where the register sits.
  assign coeff = decompress(11'(t), D);

endmodule

// File: rtl/state_unpack_cit__poly_decompress.sv
// Streaming decompressor for one packed ciphertext polynomial.
// Collects D bytes per group, unpacks eight D-bit coefficients and presents
// them decompressed on eight lanes with a valid/ready handshake.
// Optional macro STATE_UNPACK_MUL_PIPE_EN adds a MUL state that registers
// the lane results one cycle later (results unchanged, latency +1).
module state_unpack_cit__poly_decompress
  import state_unpack_cit__poly_decompress_pkg::*;
#(
  parameter int KYBER_N = 256,
  parameter int D       = 3,
  parameter int o_Width = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iStart,
  input  logic [7:0]         iByte,
  input  logic               iByteValid,
  output logic               oByteReady,
  output logic [o_Width-1:0] oPolyCoeffs0,
  output logic [o_Width-1:0] oPolyCoeffs1,
  output logic [o_Width-1:0] oPolyCoeffs2,
  output logic [o_Width-1:0] oPolyCoeffs3,
  output logic [o_Width-1:0] oPolyCoeffs4,
  output logic [o_Width-1:0] oPolyCoeffs5,
  output logic [o_Width-1:0] oPolyCoeffs6,
  output logic [o_Width-1:0] oPolyCoeffs7,
  output logic               oCoeffValid,
  input  logic               iCoeffReady,
  output logic               oBusy,
  output logic               oDone
);

  localparam int GROUPS = KYBER_N / 8;
  localparam int GW     = $clog2(GROUPS) + 1;
  localparam int WW     = 8 * D;

  logic [1:0]         state;
  logic [3:0]         byteCnt;
  logic [GW-1:0]      groupCnt;
  logic [WW-1:0]      word;
  logic [WW-1:0]      wordNext;
  logic [WW-1:0]      lanesSrc;
  logic [11:0]        laneCoeff [8];
  logic [o_Width-1:0] coeffReg  [8];
  logic               doneReg;
  logic               byteFire;
  logic               lastByte;
  logic               lastGroup;

  assign byteFire  = iByteValid && (state == ST_LOAD);
  assign lastByte  = (byteCnt == 4'(D - 1));
  assign lastGroup = (groupCnt == GW'(GROUPS - 1));

  // Word as it will look once the byte arriving this cycle is merged in,
  // so the last byte of a group can feed the lanes without waiting a cycle.
  always_comb begin
    wordNext = word;
    if (byteFire) begin
      wordNext[int'(byteCnt) * 8 +: 8] = iByte;
    end
  end

`ifdef STATE_UNPACK_MUL_PIPE_EN
  assign lanesSrc = word;
`else
  assign lanesSrc = wordNext;
`endif

  for (genvar g = 0; g < 8; g++) begin : gLane
    poly_decompress_lane #(.D(D)) uLane (
      .t     (lanesSrc[D*g +: D]),
      .coeff (laneCoeff[g])
    );
  end

  // Main FSM: byte gathering, group hand-off and polynomial bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      byteCnt  <= '0;
      groupCnt <= '0;
      word     <= '0;
      doneReg  <= 1'b0;
      for (int g = 0; g < 8; g++) coeffReg[g] <= '0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iStart) begin
            state    <= ST_LOAD;
            byteCnt  <= '0;
            groupCnt <= '0;
            word     <= '0;
          end
        end
        ST_LOAD: begin
          if (byteFire) begin
            word <= wordNext;
            if (lastByte) begin
              byteCnt <= '0;
`ifdef STATE_UNPACK_MUL_PIPE_EN
              state <= ST_MUL;
`else
              state <= ST_EMIT;
              for (int g = 0; g < 8; g++) coeffReg[g] <= o_Width'(laneCoeff[g]);
`endif
            end else begin
              byteCnt <= byteCnt + 4'd1;
            end
          end
        end
`ifdef STATE_UNPACK_MUL_PIPE_EN
        ST_MUL: begin
          state <= ST_EMIT;
          for (int g = 0; g < 8; g++) coeffReg[g] <= o_Width'(laneCoeff[g]);
        end
`endif
        ST_EMIT: begin
          if (iCoeffReady) begin
            groupCnt <= groupCnt + GW'(1);
            if (lastGroup) begin
              state   <= ST_IDLE;
              doneReg <= 1'b1;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign oByteReady   = (state == ST_LOAD);
  assign oCoeffValid  = (state == ST_EMIT);
  assign oBusy        = (state != ST_IDLE);
  assign oDone        = doneReg;
  assign oPolyCoeffs0 = coeffReg[0];
  assign oPolyCoeffs1 = coeffReg[1];
  assign oPolyCoeffs2 = coeffReg[2];
  assign oPolyCoeffs3 = coeffReg[3];
  assign oPolyCoeffs4 = coeffReg[4];
  assign oPolyCoeffs5 = coeffReg[5];
  assign oPolyCoeffs6 = coeffReg[6];
  assign oPolyCoeffs7 = coeffReg[7];

endmodule

// File: tb/tb_state_unpack_cit__poly_decompress.sv
// Scoreboard bench for state_unpack_cit__poly_decompress (D=3, KYBER_N=256).
// Expected groups are queued as bytes are accepted and popped on each
// output handshake. Works in either build of STATE_UNPACK_MUL_PIPE_EN.
module tb_state_unpack_cit__poly_decompress;

  localparam int D = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        iStart;
  logic [7:0]  iByte;
  logic        iByteValid;
  logic        oByteReady;
  logic [11:0] c0, c1, c2, c3, c4, c5, c6, c7;
  logic        oCoeffValid;
  logic        iCoeffReady;
  logic        oBusy;
  logic        oDone;
  logic [95:0] lanesNow;

  logic [95:0] expQ [$];
  logic [7:0]  byteQ [$];
  int          vectorCount = 0;
  int          miscompareCount = 0;
  int          doneCount = 0;
  bit          randomReady = 1'b0;

  localparam logic [95:0] SCEN1 = {12'd2913, 12'd2497, 12'd2081, 12'd1665,
                                   12'd1248, 12'd832,  12'd416,  12'd0};

  always #5 clk = ~clk;

  assign lanesNow = {c7, c6, c5, c4, c3, c2, c1, c0};

  state_unpack_cit__poly_decompress dut (
    .clk          (clk),
    .rst          (rst),
    .iStart       (iStart),
    .iByte        (iByte),
    .iByteValid   (iByteValid),
    .oByteReady   (oByteReady),
    .oPolyCoeffs0 (c0),
    .oPolyCoeffs1 (c1),
    .oPolyCoeffs2 (c2),
    .oPolyCoeffs3 (c3),
    .oPolyCoeffs4 (c4),
    .oPolyCoeffs5 (c5),
    .oPolyCoeffs6 (c6),
    .oPolyCoeffs7 (c7),
    .oCoeffValid  (oCoeffValid),
    .iCoeffReady  (iCoeffReady),
    .oBusy        (oBusy),
    .oDone        (oDone)
  );

  task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference decompression of one D-byte group, straight from the formula.
  function automatic logic [95:0] modelGroup(input logic [8*D-1:0] w);
    logic [95:0] r;
    int t, v;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      t = int'((w >> (D * j)) & ((1 << D) - 1));
      v = (t * 3329 + (1 << (D - 1))) / (1 << D);
      r[12*j +: 12] = 12'(v);
    end
    return r;
  endfunction

  // Sends nBytes from byteQ in order, optionally with random valid gaps.
  task automatic applyStimulus(input int nBytes, input bit randGaps);
    logic [8*D-1:0] acc;
    int inGroup;
    acc = '0;
    inGroup = 0;
    for (int i = 0; i < nBytes; i++) begin
      logic [7:0] b;
      bit fire;
      int budget;
      b = byteQ.pop_front();
      fire = 1'b0;
      budget = 0;
      while (!fire && budget < 300) begin
        iByte = b;
        iByteValid = randGaps ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        fire = iByteValid && oByteReady;
        @(posedge clk);
        #1;
        budget++;
      end
      iByteValid = 1'b0;
      if (!fire) begin
        checkOutput("byteAccepted", 96'(fire), 96'(1));
        return;
      end
      acc[8*inGroup +: 8] = b;
      inGroup++;
      if (inGroup == D) begin
        expQ.push_back(modelGroup(acc));
        inGroup = 0;
        acc = '0;
      end
    end
  endtask

  task automatic startPoly();
    iStart = 1'b1;
    @(posedge clk);
    #1;
    iStart = 1'b0;
    checkOutput("byteReadyAfterStart", 96'(oByteReady), 96'(1));
  endtask

  task automatic waitDone(input int prev, input string tag);
    int budget;
    budget = 0;
    while (doneCount == prev && budget < 600) begin
      @(posedge clk);
      #1;
      budget++;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput(tag, 96'(doneCount - prev), 96'(1));
    checkOutput("idleAfterDone", 96'(oBusy), 96'(0));
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "ByteReady"}, 96'(oByteReady), 96'(0));
    checkOutput({tag, "CoeffValid"}, 96'(oCoeffValid), 96'(0));
    checkOutput({tag, "Busy"}, 96'(oBusy), 96'(0));
    checkOutput({tag, "Done"}, 96'(oDone), 96'(0));
    checkOutput({tag, "Lanes"}, lanesNow, 96'(0));
  endtask

  task automatic pushRandomBytes(input int n);
    for (int i = 0; i < n; i++) byteQ.push_back(8'($urandom_range(0, 255)));
  endtask

  // Output side of the scoreboard: compare every accepted group, count oDone pulses.
  always @(negedge clk) begin
    if (oCoeffValid === 1'b1 && iCoeffReady === 1'b1) begin
      if (expQ.size() == 0) checkOutput("scoreboardEmpty", 96'(expQ.size()), 96'(1));
      else checkOutput("groupLanes", lanesNow, expQ.pop_front());
    end
    if (oDone === 1'b1) begin
      doneCount++;
      checkOutput("busyLowWithDone", 96'(oBusy), 96'(0));
    end
  end

  // Random downstream back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randomReady) iCoeffReady = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [95:0] held;
    int prev;
    int budget;
    rst = 1'b1;
    iStart = 1'b0;
    iByte = '0;
    iByteValid = 1'b0;
    iCoeffReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    rst = 1'b0;

    // Polynomial A: known first group, a stalled group, then random gaps and a stray iStart.
    byteQ.push_back(8'h88);
    byteQ.push_back(8'hC6);
    byteQ.push_back(8'hFA);
    pushRandomBytes(93);
    prev = doneCount;
    startPoly();
    applyStimulus(3, 1'b0);
`ifdef STATE_UNPACK_MUL_PIPE_EN
    checkOutput("mulLatencyNotYet", 96'(oCoeffValid), 96'(0));
    @(posedge clk);
    #1;
`endif
    checkOutput("firstGroupValid", 96'(oCoeffValid), 96'(1));
    checkOutput("firstGroupLanes", lanesNow, SCEN1);
    @(posedge clk);
    #1;
    iCoeffReady = 1'b0;
    applyStimulus(3, 1'b0);
    budget = 0;
    while (oCoeffValid !== 1'b1 && budget < 10) begin
      @(posedge clk);
      #1;
      budget++;
    end
    checkOutput("stallGroupValid", 96'(oCoeffValid), 96'(1));
    held = lanesNow;
    iByte = byteQ[0];
    iByteValid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checkOutput("stallLanesStable", lanesNow, held);
      checkOutput("stallByteReady", 96'(oByteReady), 96'(0));
      checkOutput("stallValidHeld", 96'(oCoeffValid), 96'(1));
    end
    iByteValid = 1'b0;
    iCoeffReady = 1'b1;
    applyStimulus(45, 1'b1);
    iStart = 1'b1;
    @(posedge clk);
    #1;
    iStart = 1'b0;
    checkOutput("busyAfterStrayStart", 96'(oBusy), 96'(1));
    applyStimulus(45, 1'b1);
    waitDone(prev, "doneOncePolyA");

    // Polynomial B: all 0xFF, every lane decodes to 2913.
    for (int i = 0; i < 96; i++) byteQ.push_back(8'hFF);
    prev = doneCount;
    startPoly();
    applyStimulus(96, 1'b0);
    waitDone(prev, "doneOncePolyB");

    // Polynomial C: abandoned by reset after 40 bytes.
    pushRandomBytes(40);
    startPoly();
    applyStimulus(40, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkIdleOutputs("midReset");
    checkOutput("noPendingAfterReset", 96'(expQ.size()), 96'(0));

    // Polynomial D: random data, random valid gaps and random downstream ready.
    pushRandomBytes(96);
    prev = doneCount;
    randomReady = 1'b1;
    startPoly();
    applyStimulus(96, 1'b1);
    randomReady = 1'b0;
    @(posedge clk);
    #1;
    iCoeffReady = 1'b1;
    waitDone(prev, "doneOncePolyD");

    checkOutput("scoreboardDrained", 96'(expQ.size()), 96'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
